// File: rtl/cv32e40p_pkg.sv
// Shared hardware-loop definitions: write-enable bit positions, per-set state
// encoding and the counter-to-state mapping used by every loop set.
package cv32e40p_pkg;

  localparam int HWLP_WE_START = 0;
  localparam int HWLP_WE_END   = 1;
  localparam int HWLP_WE_CNT   = 2;

  typedef enum logic [1:0] {
    HWLP_IDLE = 2'd0,
    HWLP_RUN  = 2'd1,
    HWLP_LAST = 2'd2
  } hwlp_state_e;

  // State is a pure function of the counter value it accompanies.
  function automatic hwlp_state_e hwlp_state_of(input logic is_zero, input logic is_one);
    if (is_zero)     return HWLP_IDLE;
    else if (is_one) return HWLP_LAST;
    else             return HWLP_RUN;
  endfunction

endpackage

// File: rtl/cv32e40p_hwloop_cnt.sv
// One hardware-loop counter with its IDLE/RUN/LAST state and completion pulse.
// Define CV32E40P_HWLP_CNT_SAT_EN to hold the counter at 0 on decrement instead of wrapping.
module cv32e40p_hwloop_cnt
  import cv32e40p_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 we_i,
  input  logic [CNT_WIDTH-1:0] data_i,
  input  logic                 dec_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output hwlp_state_e          state_o,
  output logic                 done_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  hwlp_state_e          state_q, state_d;
  logic                 done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (flush_i) begin
      cnt_d = '0;
    end else if (we_i) begin
      cnt_d = data_i;
    end else if (dec_i) begin
`ifdef CV32E40P_HWLP_CNT_SAT_EN
      cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
`else
      cnt_d = cnt_q - 1'b1;
`endif
      done_d = (cnt_q == CNT_WIDTH'(1));
    end
    state_d = hwlp_state_of(cnt_d == '0, cnt_d == CNT_WIDTH'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= HWLP_IDLE;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign state_o = state_q;
  assign done_o  = done_q;

endmodule

// File: rtl/cv32e40p_hwloop_bank.sv
// Bank of N_REGS hardware-loop register sets (start, end, counter) with sticky multi-decrement error.
// Optional macro CV32E40P_HWLP_CNT_SAT_EN selects saturating counters (see cv32e40p_hwloop_cnt).
module cv32e40p_hwloop_bank
  import cv32e40p_pkg::*;
#(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [31:0]                         hwlp_start_data_i,
  input  logic [31:0]                         hwlp_end_data_i,
  input  logic [31:0]                         hwlp_cnt_data_i,
  input  logic [2:0]                          hwlp_we_i,
  input  logic [N_REG_BITS-1:0]               hwlp_regid_i,
  input  logic                                valid_i,
  input  logic [N_REGS-1:0]                   hwlp_dec_cnt_i,
  input  logic                                flush_i,
  output logic [N_REGS-1:0][31:0]             hwlp_start_addr_o,
  output logic [N_REGS-1:0][31:0]             hwlp_end_addr_o,
  output logic [N_REGS-1:0][CNT_WIDTH-1:0]    hwlp_counter_o,
  output logic [N_REGS-1:0][1:0]              hwlp_state_o,
  output logic [N_REGS-1:0]                   hwlp_done_o,
  output logic                                hwlp_err_o
);

  logic err_q, err_d;
  logic unused_bits;

  assign unused_bits = ^{hwlp_start_data_i[1:0], hwlp_end_data_i[1:0], hwlp_cnt_data_i};

  for (genvar k = 0; k < N_REGS; k++) begin : g_set
    logic [31:0] start_q, end_q;
    logic        sel;
    hwlp_state_e state;

    // Out-of-range register ids never match any set, so such writes are dropped.
    assign sel = (hwlp_regid_i == N_REG_BITS'(k));

    always_ff @(posedge clk) begin
      if (rst) begin
        start_q <= '0;
        end_q   <= '0;
      end else begin
        if (sel && hwlp_we_i[HWLP_WE_START]) start_q <= {hwlp_start_data_i[31:2], 2'b00};
        if (sel && hwlp_we_i[HWLP_WE_END])   end_q   <= {hwlp_end_data_i[31:2], 2'b00};
      end
    end

    cv32e40p_hwloop_cnt #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush_i),
      .we_i    (sel && hwlp_we_i[HWLP_WE_CNT]),
      .data_i  (hwlp_cnt_data_i[CNT_WIDTH-1:0]),
      .dec_i   (valid_i && hwlp_dec_cnt_i[k]),
      .cnt_o   (hwlp_counter_o[k]),
      .state_o (state),
      .done_o  (hwlp_done_o[k])
    );

    assign hwlp_start_addr_o[k] = start_q;
    assign hwlp_end_addr_o[k]   = end_q;
    assign hwlp_state_o[k]      = state;
  end

  // More than one request bit set: clearing the lowest set bit leaves something.
  assign err_d = err_q | (valid_i && |(hwlp_dec_cnt_i & (hwlp_dec_cnt_i - 1'b1)));

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign hwlp_err_o = err_q;

endmodule

// File: tb/tb_cv32e40p_hwloop_bank.sv
// Directed bench for cv32e40p_hwloop_bank with N_REGS=3 and CNT_WIDTH=8.
module tb_cv32e40p_hwloop_bank;

  localparam int NR = 3;
  localparam int CW = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [31:0]             start_data = '0;
  logic [31:0]             end_data = '0;
  logic [31:0]             cnt_data = '0;
  logic [2:0]              we = '0;
  logic [1:0]              regid = '0;
  logic                    valid = 1'b0;
  logic [NR-1:0]           dec = '0;
  logic                    flush = 1'b0;
  logic [NR-1:0][31:0]     start_addr;
  logic [NR-1:0][31:0]     end_addr;
  logic [NR-1:0][CW-1:0]   counter;
  logic [NR-1:0][1:0]      state;
  logic [NR-1:0]           done;
  logic                    err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cv32e40p_hwloop_bank #(
    .N_REGS(NR),
    .CNT_WIDTH(CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .hwlp_start_data_i (start_data),
    .hwlp_end_data_i   (end_data),
    .hwlp_cnt_data_i   (cnt_data),
    .hwlp_we_i         (we),
    .hwlp_regid_i      (regid),
    .valid_i           (valid),
    .hwlp_dec_cnt_i    (dec),
    .flush_i           (flush),
    .hwlp_start_addr_o (start_addr),
    .hwlp_end_addr_o   (end_addr),
    .hwlp_counter_o    (counter),
    .hwlp_state_o      (state),
    .hwlp_done_o       (done),
    .hwlp_err_o        (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    rst = 1'b0; we = '0; valid = 1'b0; dec = '0; flush = 1'b0;
  endtask

  task automatic write_cnt(input logic [1:0] id, input logic [31:0] v);
    regid = id; we = 3'b100; cnt_data = v;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset;
    rst = 1'b1; we = 3'b111; start_data = 32'hFFFF_FFFF; cnt_data = 32'h5;
    tick();
    idle_inputs();
    total++; if (counter !== '0) begin bad++; $display("FAIL reset_cnt got=%h want=0", counter); end
    total++; if (state !== '0) begin bad++; $display("FAIL reset_state got=%h want=0", state); end
    total++; if (done !== '0 || err !== 1'b0) begin bad++; $display("FAIL reset_flags done=%b err=%b want 0/0", done, err); end
    total++; if (start_addr !== '0 || end_addr !== '0) begin bad++; $display("FAIL reset_addr start=%h end=%h want 0", start_addr, end_addr); end
  endtask

  task automatic test_addr;
    regid = 2'd1; we = 3'b011; start_data = 32'h103; end_data = 32'h207;
    tick();
    idle_inputs();
    total++; if (start_addr[1] !== 32'h100) begin bad++; $display("FAIL addr_start1 got=%h want=00000100", start_addr[1]); end
    total++; if (end_addr[1] !== 32'h204) begin bad++; $display("FAIL addr_end1 got=%h want=00000204", end_addr[1]); end
    total++; if (start_addr[0] !== 32'h0 || end_addr[0] !== 32'h0) begin bad++; $display("FAIL addr_set0 start=%h end=%h want 0", start_addr[0], end_addr[0]); end
    total++; if (counter[1] !== 8'h0) begin bad++; $display("FAIL addr_no_cnt got=%h want=00", counter[1]); end
  endtask

  task automatic test_regid_oob;
    regid = 2'd3; we = 3'b111; start_data = 32'h555; end_data = 32'h777; cnt_data = 32'h9;
    tick();
    idle_inputs();
    total++; if (start_addr[1] !== 32'h100 || start_addr[2] !== 32'h0 || start_addr[0] !== 32'h0) begin bad++; $display("FAIL oob_start got=%h", start_addr); end
    total++; if (counter !== '0) begin bad++; $display("FAIL oob_cnt got=%h want=0", counter); end
  endtask

  task automatic test_count;
    logic [CW-1:0] exp_cnt [3] = '{8'd2, 8'd1, 8'd0};
    logic [1:0]    exp_st  [3] = '{2'd1, 2'd2, 2'd0};
    logic          exp_dn  [3] = '{1'b0, 1'b0, 1'b1};
    write_cnt(2'd0, 32'h103);
    total++; if (counter[0] !== 8'd3 || state[0] !== 2'd1) begin bad++; $display("FAIL cnt_load got=%h/%h want=03/1", counter[0], state[0]); end
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; dec = 3'b001;
      tick();
      total++;
      if (counter[0] !== exp_cnt[i] || state[0] !== exp_st[i] || done[0] !== exp_dn[i]) begin
        bad++;
        $display("FAIL cnt_dec%0d got cnt=%h st=%h done=%b want cnt=%h st=%h done=%b",
                 i, counter[0], state[0], done[0], exp_cnt[i], exp_st[i], exp_dn[i]);
      end
    end
    idle_inputs();
    tick();
    total++; if (done !== '0) begin bad++; $display("FAIL cnt_done_once got=%b want=000", done); end
  endtask

  task automatic test_write_prio;
    write_cnt(2'd1, 32'd6);
    regid = 2'd0; we = 3'b100; cnt_data = 32'd5; valid = 1'b1; dec = 3'b011;
    tick();
    idle_inputs();
    total++; if (counter[0] !== 8'd5 || state[0] !== 2'd1) begin bad++; $display("FAIL prio_set0 got=%h/%h want=05/1", counter[0], state[0]); end
    total++; if (counter[1] !== 8'd5) begin bad++; $display("FAIL prio_set1 got=%h want=05", counter[1]); end
  endtask

  task automatic test_valid_gate;
    valid = 1'b0; dec = 3'b111;
    tick();
    idle_inputs();
    total++; if (counter[0] !== 8'd5 || counter[1] !== 8'd5 || counter[2] !== 8'd0) begin bad++; $display("FAIL valid_gate got=%h", counter); end
  endtask

  task automatic test_flush;
    write_cnt(2'd0, 32'd4);
    write_cnt(2'd1, 32'd7);
    flush = 1'b1; valid = 1'b1; dec = 3'b001; regid = 2'd1; we = 3'b100; cnt_data = 32'd3;
    tick();
    idle_inputs();
    total++; if (counter !== '0 || state !== '0) begin bad++; $display("FAIL flush_clear cnt=%h st=%h want 0", counter, state); end
    total++; if (done !== '0) begin bad++; $display("FAIL flush_done got=%b want=000", done); end
    total++; if (start_addr[1] !== 32'h100 || end_addr[1] !== 32'h204) begin bad++; $display("FAIL flush_addr got=%h/%h want 100/204", start_addr[1], end_addr[1]); end
  endtask

  task automatic test_err;
    rst = 1'b1; tick(); idle_inputs();
    write_cnt(2'd0, 32'd2);
    write_cnt(2'd1, 32'd3);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_pre got=%b want=0", err); end
    valid = 1'b1; dec = 3'b011;
    tick();
    idle_inputs();
    total++; if (counter[0] !== 8'd1 || state[0] !== 2'd2 || counter[1] !== 8'd2) begin bad++; $display("FAIL err_dec got=%h/%h/%h want 01/2/02", counter[0], state[0], counter[1]); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", err); end
    tick(); tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err); end
    rst = 1'b1; tick(); idle_inputs();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_rst got=%b want=0", err); end
  endtask

  task automatic test_wrap;
    logic [CW-1:0] exp_c;
    logic [1:0]    exp_s;
`ifdef CV32E40P_HWLP_CNT_SAT_EN
    exp_c = 8'h00; exp_s = 2'd0;
`else
    exp_c = 8'hFF; exp_s = 2'd1;
`endif
    valid = 1'b1; dec = 3'b100;
    tick();
    idle_inputs();
    total++; if (counter[2] !== exp_c || state[2] !== exp_s) begin bad++; $display("FAIL wrap got=%h/%h want=%h/%h", counter[2], state[2], exp_c, exp_s); end
    total++; if (done[2] !== 1'b0) begin bad++; $display("FAIL wrap_done got=%b want=0", done[2]); end
  endtask

  task automatic test_reset_override;
    write_cnt(2'd2, 32'd1);
    regid = 2'd0; we = 3'b111; start_data = 32'h40; cnt_data = 32'd9;
    rst = 1'b1; valid = 1'b1; dec = 3'b101; flush = 1'b1;
    tick();
    idle_inputs();
    total++; if (counter !== '0 || state !== '0 || done !== '0 || start_addr[0] !== 32'h0) begin bad++; $display("FAIL rst_override cnt=%h st=%h done=%b s0=%h", counter, state, done, start_addr[0]); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_addr();
    test_regid_oob();
    test_count();
    test_write_prio();
    test_valid_gate();
    test_flush();
    test_err();
    test_wrap();
    test_reset_override();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
